// File: rtl/prog_fsm_pkg.sv
// Shared types and constants for the programmable Moore state machine.
package prog_fsm_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_e;

  localparam logic SEL_TRANS = 1'b0;
  localparam logic SEL_OUT   = 1'b1;

  function automatic int unsigned cfg_width(input int unsigned st_w, input int unsigned out_w);
    return (st_w > out_w) ? st_w : out_w;
  endfunction

endpackage

// File: rtl/prog_fsm_tbl.sv
// Single-write-port table with asynchronous read; holds no reset state.
module prog_fsm_tbl #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_fsm.sv
// Run-time programmable table-driven Moore FSM; self-loads counter defaults after reset.
// Optional visited-state mask enabled by defining PROG_FSM_VISITED_EN.
module prog_fsm
  import prog_fsm_pkg::*;
#(
  parameter int unsigned IN_W        = 2,
  parameter int unsigned ST_W        = 3,
  parameter int unsigned OUT_W       = 3,
  parameter int unsigned RESET_STATE = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [IN_W-1:0]                    a,
  output logic [OUT_W-1:0]                   saida,
  output logic [ST_W-1:0]                    state_o,
  output logic                               busy,
`ifdef PROG_FSM_VISITED_EN
  input  logic                               clr_visited,
  output logic [2**ST_W-1:0]                 visited,
`endif
  input  logic                               cfg_we,
  input  logic                               cfg_sel,
  input  logic [IN_W+ST_W-1:0]               cfg_addr,
  input  logic [cfg_width(ST_W, OUT_W)-1:0]  cfg_data,
  output logic                               cfg_ack
);

  localparam int unsigned AW = IN_W + ST_W;

  ctrl_e            ctrl_q, ctrl_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [ST_W-1:0]  state_q, state_d;
  logic             ack_q, ack_d;

  logic             t_we, o_we;
  logic [AW-1:0]    t_waddr;
  logic [ST_W-1:0]  t_wdata, t_rdata, o_waddr;
  logic [OUT_W-1:0] o_wdata, o_rdata;
  logic             init_last, step;

  assign init_last = (ctrl_q == INIT) && (&idx_q);
  assign step      = (ctrl_q == RUN) && en;

  always_comb begin
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    state_d = state_q;
    ack_d   = 1'b0;
    t_we    = 1'b0;
    t_waddr = idx_q;
    t_wdata = idx_q[ST_W-1:0] + ST_W'(1);
    o_we    = 1'b0;
    o_waddr = idx_q[ST_W-1:0];
    o_wdata = OUT_W'(idx_q[ST_W-1:0]);
    if (ctrl_q == INIT) begin
      t_we  = 1'b1;
      o_we  = (idx_q[AW-1:ST_W] == '0);
      idx_d = idx_q + AW'(1);
      if (init_last) ctrl_d = RUN;
    end else begin
      // Table read is asynchronous, so a same-edge write never affects this step.
      if (en) state_d = t_rdata;
      ack_d   = cfg_we;
      t_we    = cfg_we && (cfg_sel == SEL_TRANS);
      t_waddr = cfg_addr;
      t_wdata = cfg_data[ST_W-1:0];
      o_we    = cfg_we && (cfg_sel == SEL_OUT);
      o_waddr = cfg_addr[ST_W-1:0];
      o_wdata = cfg_data[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= INIT;
      idx_q   <= '0;
      state_q <= ST_W'(RESET_STATE);
      ack_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  prog_fsm_tbl #(.AW(AW), .DW(ST_W)) u_trans (
    .clk     (clk),
    .we_i    (t_we),
    .waddr_i (t_waddr),
    .wdata_i (t_wdata),
    .raddr_i ({a, state_q}),
    .rdata_o (t_rdata)
  );

  prog_fsm_tbl #(.AW(ST_W), .DW(OUT_W)) u_out (
    .clk     (clk),
    .we_i    (o_we),
    .waddr_i (o_waddr),
    .wdata_i (o_wdata),
    .raddr_i (state_q),
    .rdata_o (o_rdata)
  );

  assign busy    = (ctrl_q == INIT);
  assign saida   = (ctrl_q == RUN) ? o_rdata : '0;
  assign state_o = state_q;
  assign cfg_ack = ack_q;

`ifdef PROG_FSM_VISITED_EN
  logic [2**ST_W-1:0] vis_q, vis_d;

  // Clear is applied first so a coinciding entry survives it.
  always_comb begin
    vis_d = clr_visited ? '0 : vis_q;
    if (init_last) vis_d[RESET_STATE] = 1'b1;
    if (step)      vis_d[t_rdata]     = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vis_q <= '0;
    else        vis_q <= vis_d;
  end

  assign visited = vis_q;
`endif

endmodule
